// File: rtl/pll_phase_pkg.sv
// Shared types for the PLL dynamic phase-shift sequencer.
// Holds the sequencer state encoding, the latched command record and a
// small helper used to size counters at elaboration time.
package pll_phase_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    PULSE    = 3'd2,
    GAP      = 3'd3,
    LOCKWAIT = 3'd4,
    DONE     = 3'd5
  } state_e;

  // Command fields held for the whole command. The step count is a working
  // down-counter whose width follows the STEP_W parameter, so it is kept as
  // its own register in the top rather than inside this record.
  typedef struct packed {
    logic [1:0] sel;
    logic       dir;
    logic       load;
  } cmd_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the asynchronous PLL lock flag into clk_i.
module pll_lock_sync (
  input  logic clk_i,
  input  logic reset,
  input  logic locked,
  output logic locked_s
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: shift the raw flag through two stages.
  always_comb begin
    meta_d = locked;
    sync_d = meta_q;
  end

  // Synchroniser stages, cleared by the shared asynchronous reset.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign locked_s = sync_q;

endmodule

// File: rtl/pll_phase_ctrl.sv
// Sequencer for the ECP5 PLL dynamic phase-shift port.
// Turns one "shift output N by K fine steps" command into timed PHASESTEP
// pulses (or a single PHASELOADREG pulse), then waits for lock and reports
// done or a sticky timeout. Define PLL_PHASE_TRACK_EN to add the phase_o
// position counters (one per PLL output, modulo PHASE_MOD).
//
// Handshake: a command is taken on the clk_i edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE, and the command
// fields are only sampled on that edge.
module pll_phase_ctrl
  import pll_phase_pkg::*;
#(
  parameter int STEP_W       = 8,
  parameter int SETUP_CYC    = 2,
  parameter int PULSE_CYC    = 4,
  parameter int GAP_CYC      = 4,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int PHASE_MOD    = 64
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_sel,
  input  logic              cmd_dir,
  input  logic              cmd_load,
  input  logic [STEP_W-1:0] cmd_steps,
  output logic [1:0]        phasesel,
  output logic              phasedir,
  output logic              phasestep,
  output logic              phaseloadreg,
  input  logic              locked,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
`ifdef PLL_PHASE_TRACK_EN
  output logic [$clog2(PHASE_MOD)-1:0] phase_o [4],
`endif
  output state_e            dbg_state_o
);

  // One shared counter serves setup/pulse/gap countdowns and the lock timer.
  localparam int CNT_MAX = max_int(max_int(SETUP_CYC, PULSE_CYC),
                                   max_int(GAP_CYC, LOCK_TIMEOUT));
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STEP_W-1:0]  steps_q, steps_d;
  cmd_t               cmd_q, cmd_d;
  logic               step_q, step_d;
  logic               load_q, load_d;
  logic               tmo_q, tmo_d;
  logic               locked_s;

  pll_lock_sync u_lock_sync (
    .clk_i    (clk_i),
    .reset    (reset),
    .locked   (locked),
    .locked_s (locked_s)
  );

  // Next-state, counters and pulse outputs of the sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    steps_d = steps_q;
    cmd_d   = cmd_q;
    tmo_d   = tmo_q;
    step_d  = 1'b0;
    load_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_d   = '{sel: cmd_sel, dir: cmd_dir, load: cmd_load};
          steps_d = cmd_steps;
          tmo_d   = 1'b0;
          if (!cmd_load && (cmd_steps == '0)) begin
            state_d = DONE;
          end else begin
            state_d = SETUP;
            cnt_d   = SETUP_LD;
          end
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = PULSE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
          // Non-zero here: a step command only reaches PULSE with steps left.
          if (!cmd_q.load) steps_d = steps_q - 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (!cmd_q.load && (steps_q != '0)) begin
            state_d = SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            state_d = LOCKWAIT;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LOCKWAIT: begin
        if (locked_s) begin
          state_d = DONE;
        end else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Registered so the PLL sees clean edges; load and step are exclusive.
    step_d = (state_d == PULSE) && !cmd_d.load;
    load_d = (state_d == PULSE) &&  cmd_d.load;
  end

  // Sequencer registers; reset drops the pulse outputs without a clock.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      steps_q <= '0;
      cmd_q   <= '0;
      step_q  <= 1'b0;
      load_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      steps_q <= steps_d;
      cmd_q   <= cmd_d;
      step_q  <= step_d;
      load_q  <= load_d;
      tmo_q   <= tmo_d;
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign phasesel     = cmd_q.sel;
  assign phasedir     = cmd_q.dir;
  assign phasestep    = step_q;
  assign phaseloadreg = load_q;
  assign timeout_err  = tmo_q;
  assign dbg_state_o  = state_q;

`ifdef PLL_PHASE_TRACK_EN
  localparam int PH_W = $clog2(PHASE_MOD);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASE_MOD - 1);

  logic [PH_W-1:0] phase_q [4];
  logic [PH_W-1:0] phase_d [4];

  // Position tracking: update on the edge where a pulse output rises.
  always_comb begin
    for (int i = 0; i < 4; i++) phase_d[i] = phase_q[i];
    if (step_d && !step_q) begin
      if (cmd_q.dir) begin
        phase_d[cmd_q.sel] = (phase_q[cmd_q.sel] == PH_LAST) ? '0
                             : phase_q[cmd_q.sel] + 1'b1;
      end else begin
        phase_d[cmd_q.sel] = (phase_q[cmd_q.sel] == '0) ? PH_LAST
                             : phase_q[cmd_q.sel] - 1'b1;
      end
    end
    if (load_d && !load_q) phase_d[cmd_q.sel] = '0;
  end

  // Position counter registers.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) phase_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) phase_q[i] <= phase_d[i];
    end
  end

  assign phase_o = phase_q;
`endif

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Bench for pll_phase_ctrl with default parameters.
module tb_pll_phase_ctrl;
  import pll_phase_pkg::*;

  localparam int PHASE_MOD = 64;
  localparam int EW        = 49;

  logic       clk_i = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_sel = '0;
  logic       cmd_dir = 1'b0;
  logic       cmd_load = 1'b0;
  logic [7:0] cmd_steps = '0;
  logic [1:0] phasesel;
  logic       phasedir;
  logic       phasestep;
  logic       phaseloadreg;
  logic       locked = 1'b1;
  logic       busy;
  logic       done;
  logic       timeout_err;
  state_e     dbg_state;
`ifdef PLL_PHASE_TRACK_EN
  logic [5:0] phase_o [4];
`endif

  pll_phase_ctrl dut (
    .clk_i        (clk_i),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_sel      (cmd_sel),
    .cmd_dir      (cmd_dir),
    .cmd_load     (cmd_load),
    .cmd_steps    (cmd_steps),
    .phasesel     (phasesel),
    .phasedir     (phasedir),
    .phasestep    (phasestep),
    .phaseloadreg (phaseloadreg),
    .locked       (locked),
    .busy         (busy),
    .done         (done),
    .timeout_err  (timeout_err),
`ifdef PLL_PHASE_TRACK_EN
    .phase_o      (phase_o),
`endif
    .dbg_state_o  (dbg_state)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0] sel;
    logic       dir;
    logic       load;
    logic [7:0] steps;
    logic       lock;
    int         exp_pulses;
    int         exp_loads;
    int         exp_done;
    logic       exp_tmo;
  } vec_t;

  vec_t          vecs [10];
  logic [EW-1:0] exp_q [$];
  int            errors = 0;
  int            checks = 0;
  int            exp_phase [4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int sel, input int dir, input int load,
                              input int steps, input int lock, input int p,
                              input int l, input int d, input int t);
    vec_t v;
    v.sel = 2'(sel); v.dir = 1'(dir); v.load = 1'(load);
    v.steps = 8'(steps); v.lock = 1'(lock);
    v.exp_pulses = p; v.exp_loads = l; v.exp_done = d; v.exp_tmo = 1'(t);
    return v;
  endfunction

  // Cycle index c counts negedges after the accept edge (c=0 right after it).
  task automatic run_vec(input vec_t v);
    int pulses = 0, loads = 0, done_cyc = -1, done_cnt = 0;
    int bad_pos = 0, bad_width = 0, bad_overlap = 0, bad_sd = 0, bad_busy = 0;
    int run_ps = 0, run_ld = 0, guard = 0;
    logic prev_ps = 1'b0, prev_ld = 1'b0, tmo_done = 1'b0;
    logic [EW-1:0] obs, expv;
    locked = v.lock;
    repeat (4) @(negedge clk_i);
    chk("ready_before_accept", cmd_ready, 1);
    cmd_sel = v.sel; cmd_dir = v.dir; cmd_load = v.load; cmd_steps = v.steps;
    cmd_valid = 1'b1;
    exp_q.push_back({16'(v.exp_pulses), 16'(v.exp_loads), 16'(v.exp_done), v.exp_tmo});
    for (int c = 0; c <= v.exp_done + 2; c++) begin
      @(negedge clk_i);
      if (c == 0) begin
        cmd_valid = 1'b0;
        chk("tmo_clear_on_accept", timeout_err, 0);
      end
      if (phasestep && !prev_ps) begin
        if (c != 2 + 10 * pulses) bad_pos++;
        pulses++;
      end
      if (phaseloadreg && !prev_ld) begin
        if (c != 2) bad_pos++;
        loads++;
      end
      if (!phasestep && prev_ps && run_ps != 4) bad_width++;
      if (!phaseloadreg && prev_ld && run_ld != 4) bad_width++;
      run_ps = phasestep ? run_ps + 1 : 0;
      run_ld = phaseloadreg ? run_ld + 1 : 0;
      if (phasestep && phaseloadreg) bad_overlap++;
      if (phasesel != v.sel || phasedir != v.dir) bad_sd++;
      if (busy != (c <= v.exp_done)) bad_busy++;
      if (cmd_ready != (c > v.exp_done)) bad_busy++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          tmo_done = timeout_err;
        end
      end
      prev_ps = phasestep;
      prev_ld = phaseloadreg;
    end
    chk("tmo_sticky", timeout_err, v.exp_tmo);
    obs  = {16'(pulses), 16'(loads), 16'(done_cyc), tmo_done};
    expv = exp_q.pop_front();
    chk("step_pulses", obs[48:33], expv[48:33]);
    chk("load_pulses", obs[32:17], expv[32:17]);
    chk("done_cycle", obs[16:1], expv[16:1]);
    chk("tmo_at_done", obs[0], expv[0]);
    chk("done_count", done_cnt, 1);
    chk("pulse_position", bad_pos, 0);
    chk("pulse_width", bad_width, 0);
    chk("pulse_overlap", bad_overlap, 0);
    chk("sel_dir_stable", bad_sd, 0);
    chk("busy_ready", bad_busy, 0);
    while (!cmd_ready && guard < 3000) begin
      @(negedge clk_i);
      guard++;
    end
    if (!cmd_ready) chk("return_to_idle", 0, 1);
`ifdef PLL_PHASE_TRACK_EN
    if (v.load) exp_phase[v.sel] = 0;
    else if (v.dir) exp_phase[v.sel] = (exp_phase[v.sel] + int'(v.steps)) % PHASE_MOD;
    else exp_phase[v.sel] = (exp_phase[v.sel] + PHASE_MOD - (int'(v.steps) % PHASE_MOD)) % PHASE_MOD;
    chk("phase_o", int'(phase_o[v.sel]), exp_phase[v.sel]);
`endif
  endtask

  initial begin
    int n, seen;
    for (int i = 0; i < 4; i++) exp_phase[i] = 0;

    // Vector table: sel, dir, load, steps, lock, pulses, loads, done cycle, tmo
    vecs[0] = mk(2, 1, 0, 3,   1, 3,   0, 31,   0);
    vecs[1] = mk(0, 0, 0, 0,   1, 0,   0, 0,    0);
    vecs[2] = mk(1, 1, 1, 5,   1, 0,   1, 11,   0);
    vecs[3] = mk(1, 0, 0, 1,   1, 1,   0, 11,   0);
    vecs[4] = mk(1, 1, 0, 1,   1, 1,   0, 11,   0);
    vecs[5] = mk(3, 0, 0, 1,   0, 1,   0, 1034, 1);
    vecs[6] = mk(0, 1, 0, 2,   1, 2,   0, 21,   0);
    n = $urandom_range(1, 6);
    vecs[7] = mk($urandom_range(0, 3), $urandom_range(0, 1), 0, n, 1, n, 0, 10 * n + 1, 0);
    n = $urandom_range(1, 6);
    vecs[8] = mk($urandom_range(0, 3), $urandom_range(0, 1), 0, n, 1, n, 0, 10 * n + 1, 0);
    vecs[9] = mk(2, 1, 0, 255, 1, 255, 0, 2551, 0);

    // Reset values
    repeat (2) @(negedge clk_i);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_phasestep", phasestep, 0);
    chk("rst_phaseloadreg", phaseloadreg, 0);
    chk("rst_phasesel", phasesel, 0);
    chk("rst_phasedir", phasedir, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_state", int'(dbg_state), int'(IDLE));
`ifdef PLL_PHASE_TRACK_EN
    for (int i = 0; i < 4; i++) chk("rst_phase_o", int'(phase_o[i]), 0);
`endif
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset during the second pulse of a 4-step command
    locked = 1'b1;
    repeat (4) @(negedge clk_i);
    cmd_sel = 2'd0; cmd_dir = 1'b1; cmd_load = 1'b0; cmd_steps = 8'd4;
    cmd_valid = 1'b1;
    @(negedge clk_i);
    cmd_valid = 1'b0;
    repeat (13) @(negedge clk_i);
    chk("ps_in_second_pulse", phasestep, 1);
    #2 reset = 1'b1;
    #1;
    chk("ps_async_drop", phasestep, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (2) @(negedge clk_i);
    reset = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (done || busy) seen++;
    end
    chk("no_done_after_abort", seen, 0);
    for (int i = 0; i < 4; i++) exp_phase[i] = 0;
    run_vec(mk(2, 1, 0, 1, 1, 1, 0, 11, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
